chunked_adder: RTL
==================

# chunked_adder

Multi-cycle, parametrised integer adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock and holds a registered carry between chunks. It is the sequential successor to the single-bit half adder in the arithmetic library. It trades latency for a short critical path: one CHUNK-bit ripple per cycle. It sits between a valid/ready producer and a valid/ready consumer, and replaces wide combinational adders on timing-critical datapaths.

## Interface
- WIDTH, default 32: operand and result width. Must be a positive multiple of CHUNK.
- CHUNK, default 8: bits added per cycle, 1..WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only when mode=0.
- mode  in  1  0 = add (a+b+cin); 1 = subtract (a+~b+1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB. For subtract, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, the effective b (b or ~b), and the initial carry (cin, or 1 for subtract).
  - Clear the chunk index k to 0 and go to CALC.
- CALC:
  - Each cycle, add chunk k of A, chunk k of effective B and the carry register.
  - Write the CHUNK-bit result into sum bits [k*CHUNK +: CHUNK] and update the carry register.
  - After the chunk with k=NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and overflow are held stable until out_ready=1, then go to IDLE.
- overflow = (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]). Computed on the final chunk.
- Inputs are ignored outside IDLE, even if in_valid=1.
- Width rule: the carry register is 1 bit and the index k is $clog2(NCHUNK) bits (min 1). No bits beyond WIDTH are produced.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, k=0, carry=0.
- Acceptance edge E0 (in_valid && in_ready): in_ready falls after E0.
- out_valid rises after edge E0+NCHUNK, i.e. latency NCHUNK cycles. For NCHUNK=1, out_valid is high the cycle after acceptance.
- Handoff edge: the edge where out_valid && out_ready.
  - out_valid falls after the handoff edge.
  - in_ready rises after the handoff edge. There is no same-cycle bypass, so throughput is one operation per NCHUNK+2 cycles minimum.
- out_ready is ignored while out_valid=0.
- sum is undefined-but-stable during CALC. Consumers sample it only when out_valid=1.
- Reset asserted in CALC or DONE aborts the operation: the result is lost and no out_valid pulse is emitted.
- Back-pressure: DONE may hold indefinitely with outputs bit-stable.

## Structure
- Package chunked_adder_pkg:
  - state enum {IDLE, CALC, DONE}.
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module chunk_add: purely combinational CHUNK-bit ripple adder with ports (x, y, ci → s, co), built from the library half/full adder cells. Instantiated once; the top level muxes chunk k into it.
- Top level holds the FSM, operand registers, carry register, index counter and result register.

## Test plan
- Reset:
  - Assert rst mid-stream → in_ready=1, out_valid=0, sum=0, cout=0 and overflow=0 immediately, without waiting for a clock edge.
- Carry propagation across chunks (WIDTH=32, CHUNK=8): add 0xFFFFFFFF+0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. out_valid rises exactly 4 cycles after acceptance.
- Subtract with borrow: 0x00000005−0x00000007 → sum=0xFFFFFFFE, cout=0, overflow=0. Second case: 0x80000000−0x00000001 → sum=0x7FFFFFFF, cout=1, overflow=1.
- Signed overflow on add: 0x7FFFFFFF+0x00000001 → sum=0x80000000, overflow=1, cout=0.
- Back-pressure and input blocking:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: outputs stable, in_ready=0, and new operands not consumed.
  - Release out_ready → next operation accepted one cycle later.
- Reset mid-CALC and exhaustive sweep:
  - Assert rst at cycle 2 of CALC → no out_valid pulse. The next operation 0x12345678+0x11111111 gives 0x23456789.
  - Separately, at WIDTH=4 with CHUNK=1, 2 and 4, run all 512 combinations of (a, b, cin) plus all subtract cases against a behavioural model.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// Shared types and bit-level adder cells for the chunked adder.
// Cells are pure functions so the ripple chunk stays combinational.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // {carry, sum}
    function automatic logic [1:0] half_add(
        input logic x,
        input logic y
    );
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] full_add(
        input logic x,
        input logic y,
        input logic c
    );
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_add(x, y);
        h2 = half_add(h1[0], c);
        return {h1[1] | h2[1], h2[0]};
    endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
import chunked_adder_pkg::*;

module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign {c[i+1], s[i]} = full_add(x[i], y[i], c[i]);
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple per clock with a
// registered carry, framed by valid/ready handshakes on both sides.
import chunked_adder_pkg::*;

module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [KW-1:0]    k;

    logic [31:0]      base;
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             co;

    assign base = 32'(k) * 32'(CHUNK);
    assign x = a_q[base +: CHUNK];
    assign y = b_q[base +: CHUNK];

    chunk_add #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x (x),
        .y (y),
        .ci(carry),
        .s (s),
        .co(co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= (mode == MODE_SUB) ? ~b : b;
                        carry    <= (mode == MODE_SUB) ? 1'b1 : cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    sum[base +: CHUNK] <= s;
                    carry <= co;
                    if (k == KLAST) begin
                        // s[CHUNK-1] is the final sum MSB on the last chunk
                        out_valid <= 1'b1;
                        cout      <= co;
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (s[CHUNK-1] != a_q[WIDTH-1]);
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
